// File: rtl/aes_round_engine_pkg.sv
// Shared AES definitions: S-boxes, GF(2^8) helpers, round count and FSM encoding.
package aes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned nr_of(input int unsigned nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] m;
        p = '0;
        x = a;
        m = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = xtime(x);
            m = m >> 1;
        end
        return p;
    endfunction

    // Rows of the table are selected by the high nibble; the low nibble picks the byte.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        row = row << (8 * x[3:0]);
        return row[127:120];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        row = row << (8 * x[3:0]);
        return row[127:120];
    endfunction

endpackage

// File: rtl/aes_round_engine_round.sv
// One combinational AES round, forward or inverse; the final round skips (Inv)MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_dir,
    input  logic         i_final,
    output logic [127:0] o_state
);

    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
        logic [7:0] a0, a1, a2, a3, k0, k1, k2, k3;
        {a0, a1, a2, a3} = a;
        {k0, k1, k2, k3} = inv ? 32'h0e0b0d09 : 32'h02030101;
        return {gmul(a0, k0) ^ gmul(a1, k1) ^ gmul(a2, k2) ^ gmul(a3, k3),
                gmul(a1, k0) ^ gmul(a2, k1) ^ gmul(a3, k2) ^ gmul(a0, k3),
                gmul(a2, k0) ^ gmul(a3, k1) ^ gmul(a0, k2) ^ gmul(a1, k3),
                gmul(a3, k0) ^ gmul(a0, k1) ^ gmul(a1, k2) ^ gmul(a2, k3)};
    endfunction

    logic [7:0] w_in  [16];
    logic [7:0] w_rkb [16];
    logic [7:0] w_ssr [16];
    logic [7:0] w_isb [16];
    logic [7:0] w_ak  [16];
    logic [7:0] w_enc [16];
    logic [7:0] w_dec [16];
    logic [7:0] w_out [16];

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign w_in[i]  = i_state[127 - 8*i -: 8];
        assign w_rkb[i] = i_rk[127 - 8*i -: 8];
        assign w_ak[i]  = w_isb[i] ^ w_rkb[i];
        assign w_out[i] = i_dir ? w_dec[i] : w_enc[i];
    end

    // Byte index = row + 4*column; (Inv)ShiftRows is folded into the S-box input selection.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] w_mc;
        logic [31:0] w_imc;
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_ssr[r + 4*c] = sbox(w_in[r + 4*((c + r) % 4)]);
            assign w_isb[r + 4*c] = inv_sbox(w_in[r + 4*((c + 4 - r) % 4)]);
        end
        assign w_mc  = mix_col({w_ssr[4*c], w_ssr[4*c+1], w_ssr[4*c+2], w_ssr[4*c+3]}, 1'b0);
        assign w_imc = mix_col({w_ak[4*c], w_ak[4*c+1], w_ak[4*c+2], w_ak[4*c+3]}, 1'b1);
        for (genvar r = 0; r < 4; r++) begin : g_out
            assign w_enc[r + 4*c] = (i_final ? w_ssr[r + 4*c] : w_mc[31 - 8*r -: 8]) ^ w_rkb[r + 4*c];
            assign w_dec[r + 4*c] = i_final ? w_ak[r + 4*c] : w_imc[31 - 8*r -: 8];
        end
    end

    assign o_state = {w_out[0],  w_out[1],  w_out[2],  w_out[3],
                      w_out[4],  w_out[5],  w_out[6],  w_out[7],
                      w_out[8],  w_out[9],  w_out[10], w_out[11],
                      w_out[12], w_out[13], w_out[14], w_out[15]};

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES core: one round per advance, encrypt or decrypt, free-run or single-step.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              decrypt,
    input  logic                              step_mode,
    input  logic                              step,
    input  logic [127:0]                      block_in,
    input  logic [128*(nr_of(NK)+1)-1:0]      key_words,
    output logic                              ready,
    output logic                              busy,
    output logic                              done,
    output logic [127:0]                      block_out,
    output logic [127:0]                      state_out,
    output logic [3:0]                        round_idx
);

    localparam int unsigned NR = nr_of(NK);

    state_e       r_fsm;
    state_e       w_fsm_nxt;
    logic         r_dir;
    logic         r_done;
    logic [127:0] r_state;
    logic [127:0] r_block;
    logic [3:0]   r_round;

    logic         w_accept;
    logic         w_adv;
    logic         w_last;
    logic [3:0]   w_r;
    logic [3:0]   w_kidx;
    logic [127:0] w_rk;
    logic [127:0] w_round_out;
    logic [127:0] w_rks [NR+1];

    for (genvar k = 0; k <= NR; k++) begin : g_rk
        assign w_rks[k] = key_words[128*(NR-k) +: 128];
    end

    assign w_accept = (r_fsm == IDLE) && start;
    assign w_adv    = (r_fsm == RUN) && (!step_mode || step);
    assign w_r      = r_round + 4'd1;
    assign w_last   = (w_r == 4'(NR));

    // In IDLE the mux serves the initial AddRoundKey of a starting operation.
    always_comb begin
        if (r_fsm == IDLE) w_kidx = decrypt ? 4'(NR) : 4'd0;
        else               w_kidx = r_dir ? 4'(NR) - w_r : w_r;
    end
    assign w_rk = w_rks[w_kidx];

    aes_round u_round (
        .i_state (r_state),
        .i_rk    (w_rk),
        .i_dir   (r_dir),
        .i_final (w_last),
        .o_state (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (start) w_fsm_nxt = RUN;
            RUN:     if (w_adv && w_last) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (r_fsm == IDLE);
        busy  = (r_fsm == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
            r_state <= '0;
            r_block <= '0;
            r_round <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_dir   <= decrypt;
                r_state <= block_in ^ w_rk;
                r_round <= '0;
            end else if (w_adv) begin
                r_state <= w_round_out;
                r_round <= w_r;
                if (w_last) begin
                    r_block <= w_round_out;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign block_out = r_block;
    assign state_out = r_state;
    assign round_idx = r_round;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine at NK=4/6/8 using FIPS-197 known-answer vectors.
module tb_aes_round_engine;
    import aes_pkg::*;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct {
        int unsigned  inst;
        logic [127:0] blk;
        int unsigned  lat;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         decrypt;
    logic         step_mode;
    logic         step;
    logic [127:0] block_in;
    logic         start [3];
    logic [1919:0] kw   [3];
    logic         rdy   [3];
    logic         bsy   [3];
    logic         dn    [3];
    logic [127:0] bout  [3];
    logic [127:0] sout  [3];
    logic [3:0]   ridx  [3];
    logic [127:0] ct    [3];

    sb_t         sb [$];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    aes_round_engine #(.NK(4)) u_nk4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .decrypt(decrypt), .step_mode(step_mode),
        .step(step), .block_in(block_in), .key_words(kw[0][1407:0]), .ready(rdy[0]), .busy(bsy[0]),
        .done(dn[0]), .block_out(bout[0]), .state_out(sout[0]), .round_idx(ridx[0])
    );

    aes_round_engine #(.NK(6)) u_nk6 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .decrypt(decrypt), .step_mode(step_mode),
        .step(step), .block_in(block_in), .key_words(kw[1][1663:0]), .ready(rdy[1]), .busy(bsy[1]),
        .done(dn[1]), .block_out(bout[1]), .state_out(sout[1]), .round_idx(ridx[1])
    );

    aes_round_engine #(.NK(8)) u_nk8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .decrypt(decrypt), .step_mode(step_mode),
        .step(step), .block_in(block_in), .key_words(kw[2][1919:0]), .ready(rdy[2]), .busy(bsy[2]),
        .done(dn[2]), .block_out(bout[2]), .state_out(sout[2]), .round_idx(ridx[2])
    );

    // FIPS-197 key expansion; round key 0 lands in the most significant bits of the used width.
    function automatic logic [1919:0] expand(input int unsigned nk, input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] res;
        int unsigned   total;
        total = 4 * (nk + 7);
        rcon  = 8'h01;
        res   = '0;
        for (int unsigned i = 0; i < 60; i++) w[i] = '0;
        for (int unsigned i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int unsigned i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int unsigned i = 0; i < total; i++) res[32*total - 1 - 32*i -: 32] = w[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge.
    task automatic issue(input int unsigned inst, input logic dec, input logic [127:0] blk,
                         input logic [127:0] expv, input int unsigned lat, input bit track);
        sb_t e;
        decrypt     = dec;
        block_in    = blk;
        start[inst] = 1'b1;
        if (track) begin
            e.inst = inst;
            e.blk  = expv;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start[inst] = 1'b0;
    endtask

    task automatic await_done(input int unsigned lat0);
        sb_t         e;
        int unsigned lat;
        e   = sb[0];
        lat = lat0;
        while (!dn[e.inst] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check($sformatf("latency_nk%0d", 4 + 2*e.inst), 128'(lat), 128'(e.lat));
        check($sformatf("block_out_nk%0d", 4 + 2*e.inst), bout[e.inst], e.blk);
        check($sformatf("round_idx_nk%0d", 4 + 2*e.inst), 128'(ridx[e.inst]), 128'(10 + 2*e.inst));
        check($sformatf("ready_at_done_nk%0d", 4 + 2*e.inst), 128'(rdy[e.inst]), 128'(1));
    endtask

    initial begin
        int unsigned n;
        ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int i = 0; i < 3; i++) begin
            kw[i]    = expand(4 + 2*i, KEY);
            start[i] = 1'b0;
        end
        rst_n     = 1'b0;
        decrypt   = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        block_in  = '0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 128'(rdy[i]), 128'(1));
            check("rst_busy", 128'(bsy[i]), 128'(0));
            check("rst_done", 128'(dn[i]), 128'(0));
            check("rst_block_out", bout[i], '0);
            check("rst_state_out", sout[i], '0);
            check("rst_round_idx", 128'(ridx[i]), 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int unsigned i = 0; i < 3; i++) begin
            issue(i, 1'b0, PT, ct[i], 11 + 2*i, 1'b1);
            check("busy_in_run", 128'(bsy[i]), 128'(1));
            await_done(1);
            @(negedge clk);
            check("done_one_cycle", 128'(dn[i]), 128'(0));
        end

        for (int unsigned i = 0; i < 3; i++) begin
            issue(i, 1'b1, ct[i], PT, 11 + 2*i, 1'b1);
            await_done(1);
        end

        // Step mode: 1 single step, 3 idle cycles, 4 held-high steps, then free-run to the end.
        step_mode = 1'b1;
        issue(0, 1'b0, PT, ct[0], 14, 1'b1);
        check("step_state0", sout[0], 128'h00102030405060708090a0b0c0d0e0f0);
        check("step_round0", 128'(ridx[0]), 128'(0));
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step_state1", sout[0], 128'h89d810e8855ace682d1843d8cb128fe4);
        check("step_round1", 128'(ridx[0]), 128'(1));
        repeat (3) @(negedge clk);
        check("step_hold_state", sout[0], 128'h89d810e8855ace682d1843d8cb128fe4);
        check("step_hold_round", 128'(ridx[0]), 128'(1));
        check("step_hold_busy", 128'(bsy[0]), 128'(1));
        step = 1'b1;
        repeat (4) @(negedge clk);
        step = 1'b0;
        check("step_held_round", 128'(ridx[0]), 128'(5));
        step_mode = 1'b0;
        await_done(9);

        issue(0, 1'b0, PT, ct[0], 11, 1'b1);
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        decrypt  = 1'b1;
        block_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start[0] = 1'b0;
        decrypt  = 1'b0;
        await_done(4);

        issue(0, 1'b0, PT, ct[0], 11, 1'b1);
        await_done(1);
        check("done_with_ready", 128'(dn[0] & rdy[0]), 128'(1));
        issue(0, 1'b1, ct[0], PT, 11, 1'b1);
        check("block_out_holds", bout[0], ct[0]);
        await_done(1);

        issue(0, 1'b0, PT, ct[0], 11, 1'b0);
        n = 0;
        while (ridx[0] != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_round_reached", 128'(ridx[0]), 128'(5));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 128'(rdy[0]), 128'(1));
        check("mid_rst_busy", 128'(bsy[0]), 128'(0));
        check("mid_rst_done", 128'(dn[0]), 128'(0));
        check("mid_rst_block_out", bout[0], '0);
        check("mid_rst_state_out", sout[0], '0);
        check("mid_rst_round_idx", 128'(ridx[0]), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, PT, ct[0], 11, 1'b1);
        await_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative, parameterised AES datapath that executes one round per advance on a 128-bit block. It supports runtime-selectable encrypt/decrypt and an optional single-step mode for on-board round-by-round display. It consumes a precomputed key schedule from the existing `KeyExpansion` block for the configured key size. It replaces separate fully unrolled cipher and decipher instances per key size with one sequential core per key size, using a start/done handshake.

## Interface
- `NK`, default 4: key length in 32-bit words; legal values are 4, 6 and 8. `NR = NK + 6`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request a new operation; sampled only in IDLE.
- `decrypt` in 1: 0 = cipher, 1 = inverse cipher; sampled together with an accepted `start`.
- `step_mode` in 1: 1 = advance only on `step`; 0 = free-run, one round per cycle.
- `step` in 1: single-cycle advance strobe; ignored unless `step_mode` = 1 and the state is RUN.
- `block_in` in 128: input block; byte 0 = bits [127:120].
- `key_words` in 128·(NR+1): round keys; round key k = bits [128·(NR+1)−1−128k −: 128].
- `ready` out 1: high in IDLE.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when `block_out` updates.
- `block_out` out 128: result; holds until the next `done`.
- `state_out` out 128: live intermediate state, for display and BCD tap.
- `round_idx` out 4: number of rounds completed in the current or last operation.

## Operation
- FSM has two states, IDLE and RUN.
- **IDLE → RUN** on `start`:
  - Latch `decrypt` into `dir`.
  - Encrypt: `state ← block_in ^ rk[0]`. Decrypt: `state ← block_in ^ rk[NR]`.
  - `round_idx ← 0`.
- **RUN, on each advance** (every cycle if `step_mode` = 0; otherwise a cycle with `step` = 1):
  - Set r = `round_idx` + 1.
  - Encrypt: SubBytes → ShiftRows → MixColumns (omitted when r = NR) → XOR `rk[r]`.
  - Decrypt: InvShiftRows → InvSubBytes → XOR `rk[NR−r]` → InvMixColumns (omitted when r = NR).
  - `round_idx ← r`.
- **RUN → IDLE** on the advance with r = NR: `block_out ← new state`, `done` = 1 for exactly the next cycle.
- `step_mode` is sampled every cycle. Toggling it mid-operation takes effect from that cycle, and the round count is unaffected.
- `start` while busy is ignored; no queueing.
- `start` coincident with `done` is accepted: `done` is high while `ready` is already high.
- Reset, including mid-operation, drives:
  - FSM → IDLE;
  - `state`, `block_out`, `round_idx` → 0;
  - `done`, `busy` → 0; `ready` → 1.
- `key_words` must be stable from `start` until `done`; it is not latched.
- GF(2⁸) arithmetic uses reduction polynomial 0x11B. All XORs are 128-bit; there is no carry.

## Timing
- Free-run latency: `start` sampled at edge 0 → initial AddRoundKey at edge 0 → rounds at edges 1..NR → `done` high during the cycle following edge NR.
  - Result: NR+1 cycles from `start` to `done` (NK=4: 11, NK=6: 13, NK=8: 15).
- Throughput is one block per NR+1 cycles. A back-to-back `start` is allowed in the `done` cycle.
- Step mode: latency = 1 + number of accepted `step` strobes (NR needed). Held-high `step` advances every cycle.
- `state_out` and `round_idx` are registered and reflect the most recent edge.
- Critical path: one S-box + MixColumns + 128-bit XOR + key mux (NR+1:1).

## Structure
- Package `aes_pkg` holds:
  - `sbox` / `inv_sbox` functions (256-entry constant case);
  - `xtime` and `gmul` functions;
  - the `nr_of(NK)` function;
  - the FSM state enum {IDLE, RUN}.
- Sub-module `aes_round` (combinational):
  - inputs: state, round key, `dir`, `final`;
  - output: next state.
- `aes_round_engine` contains the FSM, the round counter, key select, and output registers.

## Test plan
- NK=4, encrypt, free-run, `block_in`=00112233445566778899aabbccddeeff, key 000102…0f → `done` 11 cycles after `start`, `block_out`=69c4e0d86a7b0430d8cdb78070b4c55a.
- NK=6 (key 00…17) and NK=8 (key 00…1f), same plaintext:
  - NK=6 → dda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles;
  - NK=8 → 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
- NK=4, decrypt, `block_in`=69c4e0d8…c55a → `block_out`=00112233…eeff. Repeat the decrypt check for NK=6 and NK=8.
- NK=4, `step_mode`=1:
  - after `start`, `state_out`=00102030405060708090a0b0c0d0e0f0 and `round_idx`=0;
  - after one `step`, `state_out`=89d810e8855ace682d1843d8cb128fe4 and `round_idx`=1;
  - idle cycles without `step` hold the state;
  - 10 steps → `done`.
- Assert `rst_n`=0 at round 5 → next cycle IDLE with all outputs zero and `ready`=1. A subsequent `start` yields the correct ciphertext.
- `start` pulsed during RUN → ignored, result unchanged. `start` in the `done` cycle → second operation completes 11 cycles later.
